// File: rtl/pipe_regfile_sb_pkg.sv
// Shared constants and helpers for the Y86-64 register file with pending-write scoreboard.
package y86_regfile_pkg;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NREG   = 15;
    localparam int DEF_PEND_W = 2;

    localparam logic [DEF_ADDR_W-1:0] RNONE = 4'hF;
    localparam logic [DEF_ADDR_W-1:0] RRSP  = 4'h4;

    function automatic logic is_valid_reg(input int unsigned spec,
                                          input int unsigned nreg = DEF_NREG);
        return spec < nreg;
    endfunction
endpackage

// File: rtl/pipe_regfile_sb_pend_ctr.sv
// Per-register outstanding-write counter; increments and decrements net out in one cycle.
module regfile_pend_ctr #(
    parameter int PEND_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        inc_i,
    input  logic [1:0]        dec_i,
    output logic [PEND_W-1:0] count_o,
    output logic              at_max_o,
    output logic              underflow_o
);
    localparam logic [PEND_W+1:0] MAX = {2'b00, {PEND_W{1'b1}}};

    logic [PEND_W+1:0] up, nxt;

    always_comb begin
        up          = {2'b00, count_o} + {{PEND_W{1'b0}}, inc_i};
        underflow_o = ({{PEND_W{1'b0}}, dec_i} > up);
        nxt         = underflow_o ? '0 : up - {{PEND_W{1'b0}}, dec_i};
        // issue stalls before saturation; the clamp only keeps the counter sane
        if (nxt > MAX) nxt = MAX;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_o <= '0;
        else       count_o <= nxt[PEND_W-1:0];
    end

    assign at_max_o = (count_o == {PEND_W{1'b1}});
endmodule

// File: rtl/pipe_regfile_sb.sv
// Y86-64 register file: 2 read / 2 write ports plus pending-write scoreboard.
// Write-through bypass and same-cycle busy release are enabled by REGFILE_BYPASS_EN.
module pipe_regfile_sb
    import y86_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREG   = DEF_NREG,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] srcA_i,
    input  logic [ADDR_W-1:0] srcB_i,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valB_o,
    input  logic              iss_valid_i,
    input  logic [ADDR_W-1:0] iss_dstE_i,
    input  logic [ADDR_W-1:0] iss_dstM_i,
    output logic              stall_o,
    output logic              busyA_o,
    output logic              busyB_o,
    input  logic [ADDR_W-1:0] wbE_dst_i,
    input  logic [DATA_W-1:0] wbE_val_i,
    input  logic [ADDR_W-1:0] wbM_dst_i,
    input  logic [DATA_W-1:0] wbM_val_i,
    output logic              err_o
);
    localparam logic [ADDR_W-1:0] RN   = '1;
    localparam logic [PEND_W-1:0] CMAX = '1;
    localparam logic [PEND_W-1:0] NEAR = CMAX - PEND_W'(1);

    logic [DATA_W-1:0] regs [NREG];
    logic [PEND_W-1:0] cnt  [NREG];
    logic [1:0]        inc  [NREG];
    logic [1:0]        dec  [NREG];
    logic [NREG-1:0]   at_max, uflow;
    logic              accept;

    function automatic logic ok(input logic [ADDR_W-1:0] s);
        return (s != RN) && is_valid_reg(32'(s), unsigned'(NREG));
    endfunction

    function automatic logic bad(input logic [ADDR_W-1:0] s);
        return (s != RN) && !is_valid_reg(32'(s), unsigned'(NREG));
    endfunction

    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] s);
        rd = '0;
        if (ok(s)) begin
`ifdef REGFILE_BYPASS_EN
            if      (wbM_dst_i == s) rd = wbM_val_i;
            else if (wbE_dst_i == s) rd = wbE_val_i;
            else                     rd = regs[s];
`else
            rd = regs[s];
`endif
        end
    endfunction

    function automatic logic busy(input logic [ADDR_W-1:0] s);
        busy = 1'b0;
        if (ok(s)) begin
`ifdef REGFILE_BYPASS_EN
            // the last outstanding write is forwarded, so it no longer blocks
            busy = ({2'b00, cnt[s]} > {{PEND_W{1'b0}}, dec[s]});
`else
            busy = (cnt[s] != '0);
`endif
        end
    endfunction

    assign valA_o  = rd(srcA_i);
    assign valB_o  = rd(srcB_i);
    assign busyA_o = busy(srcA_i);
    assign busyB_o = busy(srcB_i);

    always_comb begin
        stall_o = busyA_o | busyB_o;
        if (ok(iss_dstE_i) && at_max[iss_dstE_i]) stall_o = 1'b1;
        if (ok(iss_dstM_i) && at_max[iss_dstM_i]) stall_o = 1'b1;
        // popq %rsp style dual destination needs two free slots
        if (ok(iss_dstE_i) && (iss_dstE_i == iss_dstM_i) && (cnt[iss_dstE_i] >= NEAR))
            stall_o = 1'b1;
    end

    assign accept = iss_valid_i & ~stall_o;

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        localparam logic [ADDR_W-1:0] ID = ADDR_W'(g);

        assign inc[g] = {1'b0, accept && (iss_dstE_i == ID)} + {1'b0, accept && (iss_dstM_i == ID)};
        assign dec[g] = {1'b0, (wbE_dst_i == ID) && ok(ID)} + {1'b0, (wbM_dst_i == ID) && ok(ID)};

        regfile_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .inc_i      (inc[g]),
            .dec_i      (dec[g]),
            .count_o    (cnt[g]),
            .at_max_o   (at_max[g]),
            .underflow_o(uflow[g])
        );

        always_ff @(posedge clk_i) begin
            if (rst_i)                   regs[g] <= '0;
            else if (wbM_dst_i == ID)    regs[g] <= wbM_val_i;
            else if (wbE_dst_i == ID)    regs[g] <= wbE_val_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_o <= 1'b0;
        else if ((|uflow) || bad(srcA_i) || bad(srcB_i) || bad(wbE_dst_i) || bad(wbM_dst_i) ||
                 (iss_valid_i && (bad(iss_dstE_i) || bad(iss_dstM_i))))
            err_o <= 1'b1;
    end
endmodule

// File: doc/pipe_regfile_sb.md
Name: pipe_regfile_sb

Overview:
Parametrised register file with a per-register pending-write scoreboard, for the pipelined Y86-64 core. Sits between decode and writeback. Provides:
- two combinational read ports, srcA and srcB
- two synchronous write ports, E and M
- write-through bypass
- outstanding-write counters that flag read-after-write hazards and stall issue

Parameters:
DATA_W, 64, register data width
ADDR_W, 4, register specifier width
NREG, 15, number of architectural registers (ids 0..NREG-1); id 2**ADDR_W-1 is RNONE
PEND_W, 2, width of each per-register pending counter (max 2**PEND_W-1 outstanding writes)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
srcA_i  in  ADDR_W  read port A specifier (RNONE = no read)
srcB_i  in  ADDR_W  read port B specifier
valA_o  out  DATA_W  read data A
valB_o  out  DATA_W  read data B
iss_valid_i  in  1  decode issues an instruction this cycle
iss_dstE_i  in  ADDR_W  issued instruction's E destination (RNONE = none)
iss_dstM_i  in  ADDR_W  issued instruction's M destination
stall_o  out  1  issue blocked this cycle
busyA_o  out  1  srcA has an unresolved pending write
busyB_o  out  1  srcB has an unresolved pending write
wbE_dst_i  in  ADDR_W  writeback E destination (RNONE = none)
wbE_val_i  in  DATA_W  writeback E data
wbM_dst_i  in  ADDR_W  writeback M destination
wbM_val_i  in  DATA_W  writeback M data
err_o  out  1  sticky: writeback to a register with zero pending count, or specifier >= NREG other than RNONE

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset state: all registers 0, all pending counters 0, err_o 0. Reset mid-operation discards all pending state; writebacks on the reset cycle are ignored.
- Reads (combinational):
  - valX_o = 0 when srcX_i is RNONE.
  - Otherwise, with bypass: wbM_val_i if wbM_dst_i == srcX_i; else wbE_val_i if wbE_dst_i == srcX_i; else the stored value.
- Writes (on clk_i):
  - regs[wbE_dst_i] <= wbE_val_i and regs[wbM_dst_i] <= wbM_val_i, each only if its dst is not RNONE.
  - Same dst on both ports: M wins (popq %rsp semantics).
- busyX_o = (srcX_i != RNONE) && (eff_pend[srcX_i] != 0), where eff_pend = pend minus the number of writeback ports targeting that register this cycle (bypass resolves the last write).
- stall_o is asserted when any of these holds:
  - busyA_o or busyB_o
  - an issue destination counter is already at max
  - iss_dstE_i == iss_dstM_i != RNONE and the counter is at or above max-1
- Issue is accepted only when iss_valid_i && !stall_o. On acceptance: pend[iss_dstE_i] += 1 and pend[iss_dstM_i] += 1, ignoring RNONE; +2 if both name the same register.
- Writeback: pend[wbE_dst_i] -= 1 and pend[wbM_dst_i] -= 1. Same register on both ports gives -2.
- Simultaneous increment and decrement on one register net out in the same cycle.
- Counters never wrap:
  - Decrementing below 0 clamps at 0 and sets err_o.
  - Saturation on increment is prevented by stall_o.
- Specifier >= NREG other than RNONE:
  - read returns 0
  - write is ignored
  - err_o is set

Optional Feature:
REGFILE_BYPASS_EN.
- Defined: write-through bypass as above; eff_pend subtracts same-cycle writebacks.
- Undefined: reads return the stored value only, and busy uses the raw pend value. A consumer therefore stalls one extra cycle after the last writeback. Saves muxes for area-constrained builds.

Decomposition:
- Package y86_regfile_pkg holds:
  - RNONE
  - RRSP (4'h4)
  - default DATA_W, ADDR_W, PEND_W
  - function is_valid_reg(spec)
- Sub-module regfile_pend_ctr: one instance per register. Inputs: inc count 0..2, dec count 0..2. Outputs: count, at_max, underflow. Instanced by generate over NREG.

Test Plan:
- Reset, then read srcA=0, srcB=RNONE -> valA_o=0, valB_o=0, busy 0, stall_o 0, err_o 0.
- Issue dstE=3, next cycle srcA=3 -> busyA_o=1, stall_o=1. Writeback wbE_dst=3, val=64'hDEAD_BEEF -> same cycle valA_o=DEAD_BEEF, busyA_o=0 (bypass on); without REGFILE_BYPASS_EN, busy clears the following cycle.
- wbE_dst=4 val=1 and wbM_dst=4 val=2 in the same cycle -> regs[4]=2, next read valA_o=2; pend[4] drops by 2.
- Issue dstE=RRSP, dstM=RRSP (popq %rsp) -> pend[4]=2. Two single writebacks -> busy clears only after the second.
- Issue dstE=5 three times (PEND_W=2) -> pend=3. A 4th issue with iss_valid_i=1 -> stall_o=1, pend stays 3.
- Writeback to reg 6 with pend=0 -> err_o=1 and stays 1. Then rst_i=1 for one cycle -> err_o=0, all pend 0.
